ldst_ctrl: RTL and testbench
============================

Name: ldst_ctrl

Overview:
- Sequences every load/store the CPU executes: single 8/16/32-bit loads and stores, and block moves (1-4 consecutive registers).
- Sits between the decode/execute stage and the single-port data memory bus.
- Issues one memory request at a time with valid/ready handshake, aligns and extends load data, replicates store data across byte lanes.
- Reads and writes the register file for block moves and load writeback.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, data/register width (fixed 32; lane logic assumes 4 bytes)
REG_IDX_WIDTH, 4, register index width
NUM_REGS_WIDTH, 2, block-move count field width (count = field+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start_valid  in  1  operation request from execute
start_ready  out  1  high when idle; start accepted when start_valid&&start_ready
op_is_store  in  1  1=store, 0=load
op_is_block  in  1  1=block move (always 32-bit)
req_data_size  in  2  pkg_cpu::ReqDataSz32/16/8
req_signed  in  1  sign-extend load
base_addr  in  ADDR_WIDTH  effective address
store_data  in  DATA_WIDTH  data for single store
first_reg  in  REG_IDX_WIDTH  load destination / first block register (rx)
num_regs_m1  in  NUM_REGS_WIDTH  block count minus one
rf_rd_idx  out  REG_IDX_WIDTH  register-file read index (combinational read)
rf_rd_data  in  DATA_WIDTH  register-file read data
rf_wr_en  out  1  register write strobe
rf_wr_idx  out  REG_IDX_WIDTH  register write index
rf_wr_data  out  DATA_WIDTH  register write data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  request address
mem_req_we  out  1  write enable
mem_req_be  out  4  byte enables
mem_req_wdata  out  DATA_WIDTH  write data
mem_rsp_valid  in  1  response/write ack
mem_rsp_rdata  in  DATA_WIDTH  word-aligned read data, little-endian
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, operation complete

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0 except start_ready=1; latched operands cleared; outstanding request abandoned.
- States:
  - IDLE: start accepted -> latch all operands; beat count = op_is_block ? num_regs_m1+1 : 1 -> ISSUE.
  - ISSUE: mem_req_valid=1; addr/we/be/wdata held stable until mem_req_ready; no retraction. Handshake -> WAIT.
  - WAIT: await mem_rsp_valid. Last beat -> IDLE. Otherwise -> ISSUE with addr+=4, reg idx+=1, count-=1.
- Address arithmetic: modulo 2^ADDR_WIDTH (0xFFFFFFFC+4=0). Register index wraps modulo 16 (15->0).
- Byte enables:
  - 32-bit: be=4'hF.
  - 16-bit: be=addr[1]?4'b1100:4'b0011; addr[0] ignored.
  - 8-bit: be=1<<addr[1:0].
  - req_data_size=2'd3 is treated as 32-bit.
- Store data:
  - Single store: wdata = store_data replicated: {2{[15:0]}} or {4{[7:0]}}.
  - Block store: rf_rd_idx = current index during ISSUE; wdata = rf_rd_data (32-bit).
- Loads:
  - Lane extracted by be position, then zero- or sign-extended per req_signed. Block loads are raw 32-bit.
  - rf_wr_en/idx/data registered: asserted the cycle after mem_rsp_valid.
- done: pulses in the cycle after the final mem_rsp_valid, coincident with the last rf_wr and with start_ready returning high. A new start is accepted in that cycle.
- Ignored inputs:
  - mem_rsp_valid outside WAIT.
  - start_valid while busy (start_ready=0).
- Latency: accept at cycle 0; mem_req_valid from cycle 1. Minimum single op = 3 cycles to done (zero-wait memory).

Decomposition:
- pkg_cpu (existing): ReqDataSz enum, ReqDataSz32=0, ReqDataSz16=1, ReqDataSz8=2.
- New pkg_ldst: state enum LdstIdle/LdstIssue/LdstWait; constant LDST_BLOCK_STRIDE=4.
- Sub-module ldst_lane_align (combinational): be generation, store replication, load extract/extend.

Test Plan:
- Single lw base 0x100, first_reg 3, rsp 0xDEADBEEF -> req addr 0x100 we0 be F; rf_wr idx3 data 0xDEADBEEF; done 1 cycle.
- lb signed at 0x203, rdata 0x80123456 -> be 4'b1000, rf_wr_data 0xFFFFFF80; repeat unsigned -> 0x00000080.
- lh signed at 0x102, rdata 0x80011234 -> 0xFFFF8001. sh store_data 0x0000ABCD at 0x102 -> wdata 0xABCDABCD, be 4'b1100.
- Block store num_regs_m1=3, first_reg 14, base 0xFFFFFFF8 -> addrs FFFFFFF8, FFFFFFFC, 00000000, 00000004; rf_rd_idx 14, 15, 0, 1; single done after 4th ack.
- mem_req_ready low 5 cycles mid block -> valid/addr/wdata stable. start_valid pulsed while busy -> ignored. Spurious rsp_valid in ISSUE -> ignored.
- rst asserted during WAIT of 2nd block-load beat -> outputs 0 immediately, start_ready=1, no further rf_wr or done.

Source files
------------

// File: rtl/ldst_ctrl_pkg.sv
// Load/store sequencer state encoding and block-move constants.
package ldst_ctrl_pkg;
   typedef enum logic [1:0] {
      LdstIdle  = 2'd0,
      LdstIssue = 2'd1,
      LdstWait  = 2'd2
   } ldst_state_e;

   localparam int LDST_BLOCK_STRIDE = 4;
endpackage

// File: rtl/pkg_cpu.sv
// CPU-wide shared types used by the memory-facing units.
package pkg_cpu;
   typedef enum logic [1:0] {
      ReqDataSz32 = 2'd0,
      ReqDataSz16 = 2'd1,
      ReqDataSz8  = 2'd2
   } req_data_sz_e;
endpackage

// File: rtl/ldst_ctrl_lane_align.sv
// Byte-lane logic: enables, store replication, load lane extract and extend.
module ldst_lane_align
   import pkg_cpu::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      // Size code 3 falls through to full-word behaviour.
      o_be        = 4'hF;
      o_wdata     = i_store_data;
      o_load_data = i_rdata;
      case (i_size)
         ReqDataSz16: begin
            o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata     = {2{i_store_data[15:0]}};
            o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         end
         ReqDataSz8: begin
            o_be        = 4'b0001 << i_addr_lo;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/ldst_ctrl.sv
// Load/store sequencer: one memory request at a time, single ops and 1-4 beat block moves.
module ldst_ctrl
   import pkg_cpu::*;
   import ldst_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_IDX_WIDTH  = 4,
   parameter int NUM_REGS_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic                      op_is_store,
   input  logic                      op_is_block,
   input  logic [1:0]                req_data_size,
   input  logic                      req_signed,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic [REG_IDX_WIDTH-1:0]  first_reg,
   input  logic [NUM_REGS_WIDTH-1:0] num_regs_m1,
   output logic [REG_IDX_WIDTH-1:0]  rf_rd_idx,
   input  logic [DATA_WIDTH-1:0]     rf_rd_data,
   output logic                      rf_wr_en,
   output logic [REG_IDX_WIDTH-1:0]  rf_wr_idx,
   output logic [DATA_WIDTH-1:0]     rf_wr_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_WIDTH-1:0]     mem_req_addr,
   output logic                      mem_req_we,
   output logic [3:0]                mem_req_be,
   output logic [DATA_WIDTH-1:0]     mem_req_wdata,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                dbg_state
);
   ldst_state_e               r_state;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic                      r_we;
   logic                      r_block;
   logic                      r_signed;
   logic [1:0]                r_size;
   logic [DATA_WIDTH-1:0]     r_store_data;
   logic [REG_IDX_WIDTH-1:0]  r_reg_idx;
   logic [NUM_REGS_WIDTH-1:0] r_beats_left;
   logic                      r_req_valid;
   logic                      r_rf_wr_en;
   logic [REG_IDX_WIDTH-1:0]  r_rf_wr_idx;
   logic [DATA_WIDTH-1:0]     r_rf_wr_data;
   logic                      r_done;

   logic [3:0]                w_be;
   logic [DATA_WIDTH-1:0]     w_wdata;
   logic [DATA_WIDTH-1:0]     w_load_data;

   ldst_lane_align u_lane (
      .i_size       (r_size),
      .i_signed     (r_signed),
      .i_addr_lo    (r_addr[1:0]),
      .i_store_data (r_store_data),
      .i_rdata      (mem_rsp_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= LdstIdle;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_block      <= 1'b0;
         r_signed     <= 1'b0;
         r_size       <= '0;
         r_store_data <= '0;
         r_reg_idx    <= '0;
         r_beats_left <= '0;
         r_req_valid  <= 1'b0;
         r_rf_wr_en   <= 1'b0;
         r_rf_wr_idx  <= '0;
         r_rf_wr_data <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_rf_wr_en <= 1'b0;
         case (r_state)
            LdstIdle: begin
               if (start_valid) begin
                  r_addr       <= base_addr;
                  r_we         <= op_is_store;
                  r_block      <= op_is_block;
                  r_signed     <= req_signed;
                  r_size       <= op_is_block ? ReqDataSz32 : req_data_size;
                  r_store_data <= store_data;
                  r_reg_idx    <= first_reg;
                  r_beats_left <= op_is_block ? num_regs_m1 : '0;
                  r_req_valid  <= 1'b1;
                  r_state      <= LdstIssue;
               end
            end
            LdstIssue: begin
               if (mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= LdstWait;
               end
            end
            LdstWait: begin
               if (mem_rsp_valid) begin
                  if (!r_we) begin
                     r_rf_wr_en   <= 1'b1;
                     r_rf_wr_idx  <= r_reg_idx;
                     r_rf_wr_data <= w_load_data;
                  end
                  if (r_beats_left == '0) begin
                     r_done  <= 1'b1;
                     r_state <= LdstIdle;
                  end else begin
                     // Address and register index both wrap naturally at their widths.
                     r_addr       <= r_addr + ADDR_WIDTH'(LDST_BLOCK_STRIDE);
                     r_reg_idx    <= r_reg_idx + 1'b1;
                     r_beats_left <= r_beats_left - 1'b1;
                     r_req_valid  <= 1'b1;
                     r_state      <= LdstIssue;
                  end
               end
            end
            default: r_state <= LdstIdle;
         endcase
      end
   end

   // Request stays fixed from valid rising until the ready handshake; no retraction.
   assign start_ready   = (r_state == LdstIdle);
   assign busy          = (r_state != LdstIdle);
   assign done          = r_done;
   assign dbg_state     = r_state;
   assign rf_rd_idx     = r_reg_idx;
   assign rf_wr_en      = r_rf_wr_en;
   assign rf_wr_idx     = r_rf_wr_idx;
   assign rf_wr_data    = r_rf_wr_data;
   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_addr;
   assign mem_req_we    = r_req_valid & r_we;
   assign mem_req_be    = r_req_valid ? w_be : 4'h0;
   assign mem_req_wdata = !r_req_valid ? '0 : (r_block ? rf_rd_data : w_wdata);
endmodule

// File: tb/tb_ldst_ctrl.sv
// Self-checking bench for ldst_ctrl: directed scenarios plus a short random pass.
module tb_ldst_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic        op_is_store;
   logic        op_is_block;
   logic [1:0]  req_data_size;
   logic        req_signed;
   logic [31:0] base_addr;
   logic [31:0] store_data;
   logic [3:0]  first_reg;
   logic [1:0]  num_regs_m1;
   logic [3:0]  rf_rd_idx;
   logic [31:0] rf_rd_data;
   logic        rf_wr_en;
   logic [3:0]  rf_wr_idx;
   logic [31:0] rf_wr_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [3:0]  mem_req_be;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   logic [31:0] tb_rf [16];
   logic [68:0] exp_req_q [$];
   logic [35:0] exp_wr_q [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign rf_rd_data = tb_rf[rf_rd_idx];

   ldst_ctrl dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .op_is_store(op_is_store), .op_is_block(op_is_block), .req_data_size(req_data_size),
      .req_signed(req_signed), .base_addr(base_addr), .store_data(store_data),
      .first_reg(first_reg), .num_regs_m1(num_regs_m1), .rf_rd_idx(rf_rd_idx),
      .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
      .rf_wr_data(rf_wr_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
      .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // Request record layout: addr[68:37] we[36] be[35:32] wdata[31:0]; load wdata is don't-care.
   function automatic logic [68:0] mk_req(input logic [31:0] a, input logic we,
                                          input logic [3:0] be, input logic [31:0] wd);
      return {a, we, be, we ? wd : 32'h0};
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd2) return 4'b0001 << a[1:0];
      if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd2) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (sz == 2'd1) return {d[15:0], d[15:0]};
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> (8 * a[1:0]);
      if (sz == 2'd2) return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      if (sz == 2'd1) begin
         sh = a[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
         return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      end
      return rd;
   endfunction

   task automatic start_op(input logic st, input logic blk, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] sd, input logic [3:0] fr,
                           input logic [1:0] nm1);
      int n;
      n = 0;
      while (start_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      op_is_store = st; op_is_block = blk; req_data_size = sz; req_signed = sgn;
      base_addr = a; store_data = sd; first_reg = fr; num_regs_m1 = nm1;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || mem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL start_accept busy=%b valid=%b want 1 1", busy, mem_req_valid);
      end
   endtask

   // One request/response beat; optionally stalls ready and injects ignored inputs while stalled.
   task automatic mem_beat(input logic [31:0] rdata, input int stall, input bit glitch, input bit last);
      logic [68:0] exp_r, got;
      logic [35:0] exp_w;
      int n;
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout valid=%b want 1", mem_req_valid);
         return;
      end
      got = mk_req(mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata);
      exp_r = (exp_req_q.size() > 0) ? exp_req_q.pop_front() : '1;
      checks++;
      if (got !== exp_r) begin
         errors++;
         $display("FAIL req got=%h want=%h", got, exp_r);
      end
      for (int i = 0; i < stall; i++) begin
         if (glitch && i == 1) begin
            start_valid = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h5A5A5A5A;
            checks++;
            if (start_ready !== 1'b0) begin
               errors++;
               $display("FAIL start_ready_busy got=%b want 0", start_ready);
            end
         end
         @(negedge clk);
         start_valid = 1'b0;
         mem_rsp_valid = 1'b0;
         checks++;
         if (mem_req_valid !== 1'b1 ||
             mk_req(mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata) !== got) begin
            errors++;
            $display("FAIL req_stable valid=%b req=%h want 1 %h", mem_req_valid,
                     mk_req(mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata), got);
         end
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (got[36] == 1'b0) begin
         exp_w = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '1;
         checks++;
         if ({rf_wr_en, rf_wr_idx, rf_wr_data} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL rf_wr got=%b/%h/%h want 1/%h/%h", rf_wr_en, rf_wr_idx, rf_wr_data,
                     exp_w[35:32], exp_w[31:0]);
         end
      end else begin
         checks++;
         if (rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rf_wr_on_store got=%b want 0", rf_wr_en);
         end
      end
      checks++;
      if (done !== last || start_ready !== last) begin
         errors++;
         $display("FAIL done got=%b start_ready=%b want %b", done, start_ready, last);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({start_ready, busy, done, mem_req_valid, mem_req_we, mem_req_be, rf_wr_en, rf_rd_idx}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL reset got rdy=%b busy=%b done=%b v=%b we=%b be=%h wr=%b rd=%h want 1 0 0 0 0 0 0 0",
                  start_ready, busy, done, mem_req_valid, mem_req_we, mem_req_be, rf_wr_en, rf_rd_idx);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw();
      exp_req_q.push_back(mk_req(32'h100, 1'b0, 4'hF, 32'h0));
      exp_wr_q.push_back({4'd3, 32'hDEADBEEF});
      start_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 4'd3, 2'd0);
      mem_beat(32'hDEADBEEF, 0, 1'b0, 1'b1);
   endtask

   task automatic test_subword();
      exp_req_q.push_back(mk_req(32'h203, 1'b0, 4'b1000, 32'h0));
      exp_wr_q.push_back({4'd5, 32'hFFFFFF80});
      start_op(1'b0, 1'b0, 2'd2, 1'b1, 32'h203, 32'h0, 4'd5, 2'd0);
      mem_beat(32'h80123456, 0, 1'b0, 1'b1);
      exp_req_q.push_back(mk_req(32'h203, 1'b0, 4'b1000, 32'h0));
      exp_wr_q.push_back({4'd5, 32'h00000080});
      start_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h203, 32'h0, 4'd5, 2'd0);
      mem_beat(32'h80123456, 1, 1'b0, 1'b1);
      exp_req_q.push_back(mk_req(32'h102, 1'b0, 4'b1100, 32'h0));
      exp_wr_q.push_back({4'd6, 32'hFFFF8001});
      start_op(1'b0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 4'd6, 2'd0);
      mem_beat(32'h80011234, 0, 1'b0, 1'b1);
      exp_req_q.push_back(mk_req(32'h102, 1'b1, 4'b1100, 32'hABCDABCD));
      start_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 4'd0, 2'd0);
      mem_beat(32'h0, 2, 1'b0, 1'b1);
   endtask

   task automatic test_block_store();
      tb_rf[14] = 32'hE0E0E00E; tb_rf[15] = 32'hF0F0F00F;
      tb_rf[0]  = 32'h01010100; tb_rf[1]  = 32'h11111101;
      exp_req_q.push_back(mk_req(32'hFFFFFFF8, 1'b1, 4'hF, 32'hE0E0E00E));
      exp_req_q.push_back(mk_req(32'hFFFFFFFC, 1'b1, 4'hF, 32'hF0F0F00F));
      exp_req_q.push_back(mk_req(32'h00000000, 1'b1, 4'hF, 32'h01010100));
      exp_req_q.push_back(mk_req(32'h00000004, 1'b1, 4'hF, 32'h11111101));
      start_op(1'b1, 1'b1, 2'd2, 1'b0, 32'hFFFFFFF8, 32'h0, 4'd14, 2'd3);
      mem_beat(32'h0, 0, 1'b0, 1'b0);
      mem_beat(32'h0, 5, 1'b1, 1'b0);
      mem_beat(32'h0, 0, 1'b0, 1'b0);
      mem_beat(32'h0, 0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL block_idle busy=%b done=%b valid=%b want 0 0 0", busy, done, mem_req_valid);
      end
   endtask

   task automatic test_back_to_back();
      exp_req_q.push_back(mk_req(32'h300, 1'b0, 4'hF, 32'h0));
      exp_wr_q.push_back({4'd15, 32'h12345678});
      start_op(1'b0, 1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 4'd15, 2'd0);
      mem_beat(32'h12345678, 0, 1'b0, 1'b1);
      exp_req_q.push_back(mk_req(32'h304, 1'b1, 4'b0100, 32'h77777777));
      start_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h306, 32'hAAAA5577, 4'd0, 2'd0);
      exp_req_q.pop_back();
      exp_req_q.push_back(mk_req(32'h306, 1'b1, 4'b0100, 32'h77777777));
      mem_beat(32'h0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [1:0]  sz;
      logic        st, sgn;
      logic [31:0] a, sd, rd;
      logic [3:0]  fr;
      for (int k = 0; k < 8; k++) begin
         sz = 2'($urandom_range(0, 3));
         st = 1'($urandom_range(0, 1));
         sgn = 1'($urandom_range(0, 1));
         a = $urandom; sd = $urandom; rd = $urandom;
         fr = 4'($urandom_range(0, 15));
         exp_req_q.push_back(mk_req(a, st, m_be(sz, a), m_wdata(sz, sd)));
         if (!st) exp_wr_q.push_back({fr, m_load(sz, sgn, a, rd)});
         start_op(st, 1'b0, sz, sgn, a, sd, fr, 2'($urandom_range(0, 3)));
         mem_beat(rd, $urandom_range(0, 3), 1'b0, 1'b1);
      end
   endtask

   task automatic test_reset_mid_block();
      int n;
      exp_req_q.push_back(mk_req(32'h40, 1'b0, 4'hF, 32'h0));
      exp_req_q.push_back(mk_req(32'h44, 1'b0, 4'hF, 32'h0));
      exp_wr_q.push_back({4'd2, 32'h11111111});
      start_op(1'b0, 1'b1, 2'd1, 1'b1, 32'h40, 32'h0, 4'd2, 2'd3);
      mem_beat(32'h11111111, 0, 1'b0, 1'b0);
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mk_req(mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata) !== exp_req_q[0]) begin
         errors++;
         $display("FAIL rst_beat2_req got=%h want=%h",
                  mk_req(mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata), exp_req_q[0]);
      end
      exp_req_q.delete();
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({start_ready, busy, done, mem_req_valid, mem_req_be, rf_wr_en}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL rst_mid_block rdy=%b busy=%b done=%b v=%b be=%h wr=%b want 1 0 0 0 0 0",
                  start_ready, busy, done, mem_req_valid, mem_req_be, rf_wr_en);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h22222222;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rf_wr_en !== 1'b0 || done !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet wr=%b done=%b valid=%b want 0 0 0", rf_wr_en, done, mem_req_valid);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0; start_valid = 1'b0; op_is_store = 1'b0; op_is_block = 1'b0;
      req_data_size = 2'd0; req_signed = 1'b0; base_addr = '0; store_data = '0;
      first_reg = '0; num_regs_m1 = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      for (int i = 0; i < 16; i++) tb_rf[i] = 32'h1000 + 32'(i);
      #2;
      test_reset();
      test_lw();
      test_subword();
      test_block_store();
      test_back_to_back();
      test_random();
      test_reset_mid_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
